// File: rtl/y86_pkg.sv
// Shared Y86 register-file definitions: register IDs, data width and the
// write-back queue entry layout.
package y86_pkg;

  localparam int DATA_W = 64;

  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;
  localparam logic [3:0] RR8   = 4'h8;
  localparam logic [3:0] RR9   = 4'h9;
  localparam logic [3:0] RR10  = 4'hA;
  localparam logic [3:0] RR11  = 4'hB;
  localparam logic [3:0] RR12  = 4'hC;
  localparam logic [3:0] RR13  = 4'hD;
  localparam logic [3:0] RR14  = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]        dst;
    logic [DATA_W-1:0] val;
  } wb_entry_t;

  function automatic logic is_reg(input logic [3:0] id);
    return id != RNONE;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-push / one-pop circular FIFO of {dst, val} with two content-match
// ports that return the youngest queued entry for a given register.
module wb_fifo
  import y86_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = y86_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0_i,
  input  logic [3:0]               push0_dst_i,
  input  logic [DATA_W-1:0]        push0_val_i,
  input  logic                     push1_i,
  input  logic [3:0]               push1_dst_i,
  input  logic [DATA_W-1:0]        push1_val_i,
  input  logic                     pop_i,
  output logic [3:0]               head_dst_o,
  output logic [DATA_W-1:0]        head_val_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic [3:0]               srcA_i,
  input  logic [3:0]               srcB_i,
  output logic                     hitA_o,
  output logic [DATA_W-1:0]        valA_o,
  output logic                     hitB_o,
  output logic [DATA_W-1:0]        valB_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]        dst_q [DEPTH];
  logic [DATA_W-1:0] val_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] tail1;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_push;
  logic          pop_eff;

  always_comb begin
    n_push  = CW'(push0_i) + CW'(push1_i);
    pop_eff = pop_i && (count_q != '0);
    head_d  = pop_eff ? head_q + AW'(1) : head_q;
    tail_d  = tail_q + AW'(n_push);
    count_d = count_q + n_push - CW'(pop_eff);
    tail1   = tail_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // push1 is only ever issued together with push0, so it lands one slot later.
  always_ff @(posedge clk) begin
    if (push0_i) begin
      dst_q[tail_q] <= push0_dst_i;
      val_q[tail_q] <= push0_val_i;
    end
    if (push1_i) begin
      dst_q[tail1] <= push1_dst_i;
      val_q[tail1] <= push1_val_i;
    end
  end

  // Scan oldest to youngest so the last hit taken is the youngest.
  function automatic logic [DATA_W:0] youngest(input logic [3:0] src);
    logic [DATA_W:0] res;
    logic [AW-1:0]   idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((CW'(i) < count_q) && (dst_q[idx] == src)) begin
        res = {1'b1, val_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {hitA_o, valA_o} = youngest(srcA_i);
    {hitB_o, valB_o} = youngest(srcB_i);
  end

  assign head_dst_o = dst_q[head_q];
  assign head_val_o = val_q[head_q];
  assign count_o    = count_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: queues up to two register writes per instruction,
// drains them through one registered write port, and forwards pending values.
module regfile_wb_scheduler
  import y86_pkg::*;
#(
  parameter int         DEPTH  = 4,
  parameter int         DATA_W = y86_pkg::DATA_W,
  parameter logic [3:0] RNONE  = y86_pkg::RNONE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en,
  input  logic [3:0]             dstE,
  input  logic [DATA_W-1:0]      valE,
  input  logic [3:0]             dstM,
  input  logic [DATA_W-1:0]      valM,
  output logic                   stall,
  output logic                   wr_en,
  output logic [3:0]             wr_dst,
  output logic [DATA_W-1:0]      wr_val,
  input  logic [3:0]             rd_srcA,
  input  logic [3:0]             rd_srcB,
  input  logic [DATA_W-1:0]      rf_valA,
  input  logic [DATA_W-1:0]      rf_valB,
  output logic [DATA_W-1:0]      valA,
  output logic [DATA_W-1:0]      valB,
  output logic [$clog2(DEPTH):0] pend_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count;
  logic [3:0]        head_dst;
  logic [DATA_W-1:0] head_val;
  logic              accept, push_e, push_m;
  logic              p0_en, p1_en;
  logic [3:0]        p0_dst;
  logic [DATA_W-1:0] p0_val;
  logic              pop;
  logic              hitA, hitB;
  logic [DATA_W-1:0] qvalA, qvalB;

  logic              wr_en_q, wr_en_d;
  logic [3:0]        wr_dst_q, wr_dst_d;
  logic [DATA_W-1:0] wr_val_q, wr_val_d;

  // A full instruction needs two free slots; stall whenever fewer remain.
  assign stall  = (count >= CW'(DEPTH - 1));
  assign accept = wb_en && !stall;
  assign pop    = (count != '0);

  // When both results target the same register only M is written.
  always_comb begin
    push_e = accept && (dstE != RNONE) && (dstE != dstM);
    push_m = accept && (dstM != RNONE);
    p0_en  = push_e || push_m;
    p1_en  = push_e && push_m;
    p0_dst = push_e ? dstE : dstM;
    p0_val = push_e ? valE : valM;
  end

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0_i     (p0_en),
    .push0_dst_i (p0_dst),
    .push0_val_i (p0_val),
    .push1_i     (p1_en),
    .push1_dst_i (dstM),
    .push1_val_i (valM),
    .pop_i       (pop),
    .head_dst_o  (head_dst),
    .head_val_o  (head_val),
    .count_o     (count),
    .srcA_i      (rd_srcA),
    .srcB_i      (rd_srcB),
    .hitA_o      (hitA),
    .valA_o      (qvalA),
    .hitB_o      (hitB),
    .valB_o      (qvalB)
  );

  // Drain stage: queue head -> registered write port
  always_comb begin
    wr_en_d  = pop;
    wr_dst_d = pop ? head_dst : RNONE;
    wr_val_d = pop ? head_val : wr_val_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q  <= 1'b0;
      wr_dst_q <= RNONE;
      wr_val_q <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      wr_dst_q <= wr_dst_d;
      wr_val_q <= wr_val_d;
    end
  end

  assign wr_en  = wr_en_q;
  assign wr_dst = wr_dst_q;
  assign wr_val = wr_val_q;

  // Queued entries are younger than the one currently on the write port.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [3:0]        src,
    input logic              qhit,
    input logic [DATA_W-1:0] qval,
    input logic [DATA_W-1:0] rfval
  );
    if (src == RNONE)                     return '0;
    else if (qhit)                        return qval;
    else if (wr_en_q && wr_dst_q == src)  return wr_val_q;
    else                                  return rfval;
  endfunction

  always_comb begin
    valA = fwd_sel(rd_srcA, hitA, qvalA, rf_valA);
    valB = fwd_sel(rd_srcB, hitB, qvalB, rf_valB);
  end

  assign pend_cnt = count + CW'(wr_en_q);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: a queue-level reference model
// predicts writes, stall, occupancy and forwarded read data.
module tb_regfile_wb_scheduler;

  localparam int         DEPTH  = 4;
  localparam int         DATA_W = 64;
  localparam logic [3:0] RN     = 4'hF;

  typedef struct {
    logic [3:0]  dst;
    logic [63:0] val;
  } ent_t;

  logic              clk, rst, wb_en;
  logic [3:0]        dstE, dstM, rd_srcA, rd_srcB, wr_dst;
  logic [DATA_W-1:0] valE, valM, rf_valA, rf_valB, wr_val, valA, valB;
  logic              stall, wr_en;
  logic [2:0]        pend_cnt;

  regfile_wb_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RNONE(RN)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .stall(stall), .wr_en(wr_en), .wr_dst(wr_dst), .wr_val(wr_val),
    .rd_srcA(rd_srcA), .rd_srcB(rd_srcB), .rf_valA(rf_valA), .rf_valB(rf_valB),
    .valA(valA), .valB(valB), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  ent_t pend[$];
  ent_t sb[$];
  ent_t infl;
  logic infl_v   = 1'b0;
  logic last_acc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] fwd(input logic [3:0] s, input logic [63:0] rf);
    if (s == RN) return 64'd0;
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].dst == s) return pend[i].val;
    if (infl_v && infl.dst == s) return infl.val;
    return rf;
  endfunction

  // Reference model: pending list plus the entry currently on the write port.
  always @(posedge clk) begin
    if (!rst) begin
      last_acc = wb_en && !((DEPTH - pend.size()) < 2);
      if (pend.size() > 0) begin
        infl   = pend.pop_front();
        infl_v = 1'b1;
        sb.push_back(infl);
      end else begin
        infl_v = 1'b0;
      end
      if (last_acc) begin
        if (dstE != RN && dstE != dstM) pend.push_back('{dstE, valE});
        if (dstM != RN)                 pend.push_back('{dstM, valM});
      end
    end else begin
      last_acc = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("stall", {63'd0, stall}, {63'd0, ((DEPTH - pend.size()) < 2)});
    check("pend_cnt", {61'd0, pend_cnt}, 64'(pend.size() + int'(infl_v)));
    check("valA", valA, fwd(rd_srcA, rf_valA));
    check("valB", valB, fwd(rd_srcB, rf_valB));
  end

  // Write-port monitor: pops the scoreboard whenever a write is expected.
  always @(negedge clk) begin
    ent_t e;
    check("wr_en", {63'd0, wr_en}, {63'd0, (sb.size() > 0)});
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (wr_en) begin
        check("wr_dst", {60'd0, wr_dst}, {60'd0, e.dst});
        check("wr_val", wr_val, e.val);
      end
    end else begin
      check("wr_dst_idle", {60'd0, wr_dst}, {60'd0, RN});
    end
  end

  function automatic logic [3:0] rnd_reg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? RN : 4'(r + 1);
  endfunction

  task automatic rnd_reads();
    rd_srcA = rnd_reg();
    rd_srcB = rnd_reg();
    rf_valA = {$urandom, $urandom};
    rf_valB = {$urandom, $urandom};
  endtask

  // Called at posedge+1; holds the instruction while stalled.
  task automatic instr(input logic wb, input logic [3:0] dE, input logic [63:0] vE,
                       input logic [3:0] dM, input logic [63:0] vM);
    int guard;
    wb_en = wb; dstE = dE; valE = vE; dstM = dM; valM = vM;
    guard = 0;
    rnd_reads();
    forever begin
      @(posedge clk); #1;
      if (!wb || last_acc) break;
      guard++;
      if (guard > 20) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
      rnd_reads();
    end
    wb_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) instr(1'b0, RN, 64'd0, RN, 64'd0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    pend.delete(); sb.delete(); infl_v = 1'b0;
    #1;
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_wr_dst", {60'd0, wr_dst}, {60'd0, RN});
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_pend_cnt", {61'd0, pend_cnt}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b0; dstE = RN; dstM = RN; valE = '0; valM = '0;
    rd_srcA = 4'd3; rd_srcB = RN; rf_valA = 64'h1234; rf_valB = 64'h55;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    do_reset();
    idle(1);

    instr(1'b1, 4'd2, 64'd100, RN, 64'd0);
    rd_srcA = 4'd2;
    #2 check("fwd_single", valA, 64'd100);
    idle(3);

    instr(1'b1, 4'd4, 64'd8, 4'd4, 64'd40);
    idle(3);

    instr(1'b1, 4'd1, 64'd11, 4'd2, 64'd22);
    instr(1'b1, 4'd1, 64'd33, 4'd2, 64'd44);
    instr(1'b1, 4'd1, 64'd55, 4'd2, 64'd66);
    idle(6);

    instr(1'b1, 4'd5, 64'd7, RN, 64'd0);
    instr(1'b1, 4'd5, 64'd9, RN, 64'd0);
    rd_srcB = 4'd5;
    #2 check("fwd_youngest", valB, 64'd9);
    idle(4);

    instr(1'b1, 4'd1, 64'd1, 4'd2, 64'd2);
    instr(1'b1, 4'd3, 64'd3, 4'd4, 64'd4);
    do_reset();
    idle(4);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0)
        instr(1'b1, rnd_reg(), {$urandom, $urandom}, rnd_reg(), {$urandom, $urandom});
      else
        idle(1);
      if (k == 200) do_reset();
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
